// File: rtl/digit_updown_counter.sv
// Up/down counter holding binary and packed-BCD images of the same value in lock-step,
// with a clock-enable prescaler, programmable maximum, wrap/saturate mode and BCD load.
module digit_updown_counter #(
  parameter int DIGITS    = 4,
  parameter int WIDTH     = 14,
  parameter int MAX_VALUE = 9999,
  parameter int DIVIDE    = 1,
  parameter int SATURATE  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  decrement,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_bcd,
  output logic [WIDTH-1:0]      binout,
  output logic [4*DIGITS-1:0]   bcdout,
  output logic                  boundary,
  output logic                  load_error,
  output logic                  at_zero,
  output logic                  at_max
);

  localparam int BW = 4 * DIGITS;
  localparam int PW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int DW = $clog2(10 ** DIGITS);

  if ((WIDTH < $clog2(MAX_VALUE + 1)) || (MAX_VALUE < 1) ||
      (MAX_VALUE > (10 ** DIGITS) - 1) || (DIVIDE < 1)) begin : g_param_check
    $error("digit_updown_counter: illegal WIDTH/MAX_VALUE/DIVIDE combination");
  end

  // BCD image of a constant, evaluated at elaboration for the wrap-to-max value.
  function automatic logic [BW-1:0] to_bcd(input int value);
    logic [BW-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [BW-1:0]    MAX_BCD   = to_bcd(MAX_VALUE);
  localparam logic [WIDTH-1:0] MAX_BIN   = WIDTH'(MAX_VALUE);
  localparam logic [PW-1:0]    PCNT_LAST = PW'(DIVIDE - 1);
  localparam logic [DW-1:0]    MAX_DEC   = DW'(MAX_VALUE);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_n;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_n;
  logic [PW-1:0]    pcnt_q;
  logic [PW-1:0]    pcnt_n;
  logic             boundary_q;
  logic             boundary_n;
  logic             load_error_q;
  logic             load_error_n;

  logic [BW-1:0]    bcd_inc;
  logic [BW-1:0]    bcd_dec;
  logic             inc_carry;
  logic             dec_borrow;
  logic [DW-1:0]    load_value;
  logic             load_digits_ok;
  logic             load_ok;
  logic             step;
  logic             at_zero_int;
  logic             at_max_int;

  // Digit-serial BCD increment: a 9 rolls to 0 and passes the carry upward.
  always_comb begin
    bcd_inc   = bcd_q;
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // Digit-serial BCD decrement: a 0 rolls to 9 and passes the borrow upward.
  always_comb begin
    bcd_dec    = bcd_q;
    dec_borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_borrow) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          bcd_dec[4*i +: 4] = 4'd9;
        end else begin
          bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  // Horner decode of the load word; the result only matters when every digit is legal.
  always_comb begin
    load_digits_ok = 1'b1;
    load_value     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (load_bcd[4*i +: 4] > 4'd9) begin
        load_digits_ok = 1'b0;
      end
      load_value = load_value * DW'(10) + DW'(load_bcd[4*i +: 4]);
    end
    load_ok = load_digits_ok && (load_value <= MAX_DEC);
  end

  assign at_zero_int = (bin_q == '0);
  assign at_max_int  = (bin_q == MAX_BIN);

  // Load beats step; a load of either outcome restarts the prescaler phase.
  always_comb begin
    bin_n        = bin_q;
    bcd_n        = bcd_q;
    pcnt_n       = pcnt_q;
    boundary_n   = 1'b0;
    load_error_n = 1'b0;
    step         = enable && (pcnt_q == PCNT_LAST);

    if (load) begin
      pcnt_n = '0;
      if (load_ok) begin
        bcd_n = load_bcd;
        bin_n = WIDTH'(load_value);
      end else begin
        load_error_n = 1'b1;
      end
    end else if (step) begin
      pcnt_n = '0;
      if (!decrement) begin
        if (at_max_int) begin
          boundary_n = 1'b1;
          if (SATURATE == 0) begin
            bin_n = '0;
            bcd_n = '0;
          end
        end else begin
          bin_n = bin_q + WIDTH'(1);
          bcd_n = bcd_inc;
        end
      end else begin
        if (at_zero_int) begin
          boundary_n = 1'b1;
          if (SATURATE == 0) begin
            bin_n = MAX_BIN;
            bcd_n = MAX_BCD;
          end
        end else begin
          bin_n = bin_q - WIDTH'(1);
          bcd_n = bcd_dec;
        end
      end
    end else if (enable) begin
      pcnt_n = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q        <= '0;
      bcd_q        <= '0;
      pcnt_q       <= '0;
      boundary_q   <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      bin_q        <= bin_n;
      bcd_q        <= bcd_n;
      pcnt_q       <= pcnt_n;
      boundary_q   <= boundary_n;
      load_error_q <= load_error_n;
    end
  end

  assign binout     = bin_q;
  assign bcdout     = bcd_q;
  assign boundary   = boundary_q;
  assign load_error = load_error_q;
  assign at_zero    = at_zero_int;
  assign at_max     = at_max_int;

endmodule
